// File: rtl/mul_qdr_pkg.sv
// mul_qdr_pkg
//   Shared arithmetic package for the divider / reconstruction datapath.
//   Holds the default operand widths that the divider and mul_qdr share, and
//   the state encoding of the mul_qdr sequencer.
//   No ports (package).
package mul_qdr_pkg;

  // Default widths, common with the convergence divider.
  localparam int WQ_DEFAULT = 9;
  localparam int WD_DEFAULT = 9;

  // Sequencer states. The encodings are fixed so that they stay stable
  // across the arithmetic blocks that share this package.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_qdr.sv
// mul_qdr
//   Sequential radix-2 shift-add reconstruction unit: N = Q*D + R.
//   It is the inverse of the convergence divider. It rebuilds a numerator from
//   a quotient/remainder pair, one multiplier bit per cycle, with a fixed
//   latency of WQ cycles.
// Ports
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous, active-high reset
//   in_valid   in   1       q_in / d_in / r_in valid
//   in_ready   out  1       operands accepted (high only in IDLE, combinational)
//   q_in       in   WQ      quotient (multiplier), unsigned
//   d_in       in   WD      denominator (multiplicand), unsigned
//   r_in       in   WD      remainder, unsigned
//   out_valid  out  1       n_out holds a result (registered)
//   out_ready  in   1       consumer takes n_out
//   n_out      out  WQ+WD   Q*D + R, unsigned (registered)
module mul_qdr
  import mul_qdr_pkg::*;
#(
  parameter int WQ = WQ_DEFAULT,
  parameter int WD = WD_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WQ-1:0]    q_in,
  input  logic [WD-1:0]    d_in,
  input  logic [WD-1:0]    r_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WQ+WD-1:0] n_out
);

  localparam int WN = WQ + WD;
  // A 1-bit counter still works when WQ == 1, where $clog2 would give 0.
  localparam int CW = (WQ > 1) ? $clog2(WQ) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WQ - 1);

  state_t          state;
  logic [WN-1:0]   acc;
  logic [WN-1:0]   mcand;
  logic [WN-1:0]   acc_sum;
  logic [WQ-1:0]   mreg;
  logic [CW-1:0]   count;

  assign in_ready = (state == ST_IDLE);

  // Conditional partial-product add. The sum is bounded by
  // 2^WQ * (2^WD - 1), so it always fits in WN bits and needs no carry-out.
  always_comb begin
    acc_sum = acc;
    if (mreg[0]) begin
      acc_sum = acc + mcand;
    end
  end

  // Sequencer and datapath. Every multiplier bit is consumed, even when the
  // remaining bits are zero, so the latency does not depend on the data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      n_out     <= '0;
      acc       <= '0;
      mreg      <= '0;
      mcand     <= '0;
      count     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            // The remainder seeds the accumulator, so no separate final add
            // is needed.
            acc   <= WN'(r_in);
            mreg  <= q_in;
            mcand <= WN'(d_in);
            count <= '0;
            state <= ST_MUL;
          end
        end

        ST_MUL: begin
          acc   <= acc_sum;
          mcand <= mcand << 1;
          mreg  <= mreg >> 1;
          count <= count + CW'(1);
          if (count == LAST_COUNT) begin
            n_out     <= acc_sum;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Hold the result until the consumer takes it. There is no accept
          // in this cycle; IDLE begins on the following edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_qdr.sv
// tb_mul_qdr
//   Scoreboard bench for mul_qdr. The stimulus side queues the hand-computed
//   results and the accept edges. An independent monitor pops a result on
//   every output handshake. It also checks the fixed latency each time
//   out_valid rises.
module tb_mul_qdr;

  localparam int WQ = 9;
  localparam int WD = 9;
  localparam int LATENCY = WQ;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WQ-1:0]    q_in;
  logic [WD-1:0]    d_in;
  logic [WD-1:0]    r_in;
  logic             out_valid;
  logic             out_ready;
  logic [WQ+WD-1:0] n_out;

  int tests_run;
  int tests_failed;
  int cyc;
  bit rand_ready;
  bit prev_valid;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  mul_qdr #(.WQ(WQ), .WD(WD)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q_in      (q_in),
    .d_in      (d_in),
    .r_in      (r_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .n_out     (n_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: scoreboard pop on each output handshake, plus a latency check
  // on each rising edge of out_valid.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (lat_q.size() == 0) begin
          checkOutput("unexpected_valid", 32'd1, 32'd0);
        end else begin
          checkOutput("latency", 32'(cyc - lat_q.pop_front()), 32'(LATENCY));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_output", 32'(n_out), 32'hFFFF_FFFF);
        end else begin
          checkOutput("n_out", 32'(n_out), exp_q.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  // Present one operand set and wait (bounded) for it to be accepted. The
  // expected result is queued only when a result is really expected; the
  // reset-abort case passes expect_out = 0.
  task automatic applyStimulus(input int q, input int d, input int r, input int expected,
                               input bit expect_out, input bit hold_valid);
    bit accepted;
    accepted = 1'b0;
    q_in = WQ'(q);
    d_in = WD'(d);
    r_in = WD'(r);
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        checkOutput("prior_result_consumed", 32'(exp_q.size()), 32'd0);
        if (expect_out) begin
          exp_q.push_back(32'(expected));
          lat_q.push_back(cyc + 1);
        end
        accepted = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!hold_valid) in_valid = 1'b0;
  endtask

  initial begin
    bit seen;
    int q, d, r;
    tests_run = 0;
    tests_failed = 0;
    cyc = 0;
    rand_ready = 1'b0;
    prev_valid = 1'b0;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    q_in = '0;
    d_in = '0;
    r_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_n_out", 32'(n_out), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic, full-scale and zero-operand cases
    applyStimulus(7, 3, 2, 23, 1'b1, 1'b0);
    applyStimulus(511, 511, 511, 261632, 1'b1, 1'b0);
    applyStimulus(0, 200, 17, 17, 1'b1, 1'b0);
    applyStimulus(1, 0, 0, 0, 1'b1, 1'b0);
    applyStimulus(255, 2, 1, 511, 1'b1, 1'b0);
    applyStimulus(100, 100, 99, 10099, 1'b1, 1'b0);

    // Backpressure: the result must hold for 5 cycles with out_ready low.
    repeat (15) @(posedge clk);
    #1 out_ready = 1'b0;
    applyStimulus(25, 4, 3, 103, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("bp_valid_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("bp_valid_hold", 32'(out_valid), 32'd1);
      checkOutput("bp_n_out_hold", 32'(n_out), 32'd103);
      checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    checkOutput("hs_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    checkOutput("post_hs_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Reset in the middle of MUL aborts the operation.
    applyStimulus(300, 300, 300, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_n_out", 32'(n_out), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    lat_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(10, 10, 5, 105, 1'b1, 1'b0);

    // Back-to-back with in_valid held high
    applyStimulus(12, 34, 5, 413, 1'b1, 1'b1);
    applyStimulus(3, 100, 99, 399, 1'b1, 1'b0);

    // Short random run with random backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      q = int'($urandom_range(0, 511));
      d = int'($urandom_range(0, 511));
      r = int'($urandom_range(0, 511));
      applyStimulus(q, d, r, q * d + r, 1'b1, 1'b0);
    end
    rand_ready = 1'b0;

    // Drain
    #1 out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("drain_complete", 32'(seen), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
